// File: rtl/countdown_timer_with_reload.sv
// Loadable down-counter with a reload register, one-shot or periodic mode,
// and registered borrow/expired/running flags driven from a small FSM.
module countdown_timer_with_reload #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic             decrement,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] A,
  output logic             output_borrow,
  output logic             expired,
  output logic             running
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] r_q;
  logic             borrow_q;
  logic             expired_q;
  logic             running_q;

  // NOTE: every register here, flags included, is cleared asynchronously and
  // updated with non-blocking assignments so all outputs change together.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      r_q       <= '0;
      borrow_q  <= 1'b0;
      expired_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      borrow_q <= 1'b0;
      if (load) begin
        a_q       <= I;
        r_q       <= I;
        state_q   <= ST_ARMED;
        running_q <= 1'b1;
        expired_q <= 1'b0;
      end else begin
        unique case (state_q)
          ST_ARMED: begin
            if (decrement) begin
              if (a_q != '0) begin
                a_q <= a_q - WIDTH'(1);
              end else if (auto_reload) begin
                // Periodic mode: zero crossing reloads and keeps running.
                a_q      <= r_q;
                borrow_q <= 1'b1;
              end else begin
                // One-shot mode: A saturates at zero and the timer expires.
                borrow_q  <= 1'b1;
                state_q   <= ST_EXPIRED;
                running_q <= 1'b0;
                expired_q <= 1'b1;
              end
            end
          end
          ST_IDLE, ST_EXPIRED: begin
            state_q <= state_q;
          end
          default: begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            expired_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign A             = a_q;
  assign output_borrow = borrow_q;
  assign expired       = expired_q;
  assign running       = running_q;

endmodule

// File: tb/tb_countdown_timer_with_reload.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a behavioural model of the countdown timer.
module tb_countdown_timer_with_reload;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         clear;
  logic         load;
  logic         decrement;
  logic         auto_reload;
  logic [W-1:0] I;
  logic [W-1:0] A;
  logic         output_borrow;
  logic         expired;
  logic         running;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: mode 0 = idle, 1 = armed, 2 = expired.
  int m_count;
  int m_reload;
  int m_mode;
  int m_borrow;

  int t28_a[5] = '{2, 1, 0, 0, 0};
  int t28_b[5] = '{0, 0, 0, 1, 0};
  int t29_a[9] = '{1, 0, 2, 1, 0, 2, 1, 0, 2};
  int t29_b[9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};

  countdown_timer_with_reload #(.WIDTH(W)) dut (
    .clock        (clock),
    .clear        (clear),
    .load         (load),
    .decrement    (decrement),
    .auto_reload  (auto_reload),
    .I            (I),
    .A            (A),
    .output_borrow(output_borrow),
    .expired      (expired),
    .running      (running)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count  = 0;
    m_reload = 0;
    m_mode   = 0;
    m_borrow = 0;
  endtask

  task automatic model_step(input int ld, input int dec, input int ar, input int val);
    m_borrow = 0;
    if (ld != 0) begin
      m_count  = val;
      m_reload = val;
      m_mode   = 1;
    end else if (m_mode == 1 && dec != 0) begin
      if (m_count > 0) begin
        m_count = m_count - 1;
      end else begin
        m_borrow = 1;
        if (ar != 0) m_count = m_reload;
        else         m_mode  = 2;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "/A"},       32'(A),             32'(m_count));
    check({tag, "/borrow"},  32'(output_borrow), 32'(m_borrow));
    check({tag, "/running"}, 32'(running),       32'(m_mode == 1));
    check({tag, "/expired"}, 32'(expired),       32'(m_mode == 2));
  endtask

  // Drive inputs just after an edge, take the next edge, then compare.
  task automatic do_cycle(input string tag, input int ld, input int dec, input int ar, input int val);
    load        = ld[0];
    decrement   = dec[0];
    auto_reload = ar[0];
    I           = W'(val);
    @(posedge clock);
    #1;
    model_step(ld, dec, ar, val);
    check_model(tag);
  endtask

  task automatic apply_reset(input string tag);
    load      = 1'b0;
    decrement = 1'b1;
    I         = '0;
    #2;
    clear = 1'b0;
    #1;
    model_reset();
    check_model({tag, "/async"});
    @(posedge clock);
    #1;
    check_model({tag, "/held"});
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1;
    check_model({tag, "/release"});
  endtask

  initial begin
    clear       = 1'b0;
    load        = 1'b0;
    decrement   = 1'b0;
    auto_reload = 1'b0;
    I           = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_model("reset");
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1;

    // Decrement with no load after reset is ignored.
    for (int k = 0; k < 5; k++) do_cycle("idle_dec", 0, 1, 1, 0);
    check("idle_dec/A_zero", 32'(A), 0);

    // One-shot from 3.
    do_cycle("os_load", 1, 0, 0, 3);
    for (int k = 0; k < 5; k++) begin
      do_cycle("os_dec", 0, 1, 0, 0);
      check("os_tab/A", 32'(A), 32'(t28_a[k]));
      check("os_tab/borrow", 32'(output_borrow), 32'(t28_b[k]));
    end
    check("os_end/expired", 32'(expired), 1);
    check("os_end/running", 32'(running), 0);

    // Load 0 from EXPIRED, one decrement crosses zero and re-expires.
    do_cycle("exp_load0", 1, 0, 0, 0);
    check("exp_load0/running", 32'(running), 1);
    do_cycle("exp_dec", 0, 1, 0, 0);
    check("exp_dec/borrow", 32'(output_borrow), 1);
    check("exp_dec/expired", 32'(expired), 1);
    do_cycle("exp_dec2", 0, 1, 0, 0);
    check("exp_dec2/borrow", 32'(output_borrow), 0);

    // Periodic from 2.
    do_cycle("pr_load", 1, 0, 1, 2);
    for (int k = 0; k < 9; k++) begin
      do_cycle("pr_dec", 0, 1, 1, 0);
      check("pr_tab/A", 32'(A), 32'(t29_a[k]));
      check("pr_tab/borrow", 32'(output_borrow), 32'(t29_b[k]));
      check("pr_tab/running", 32'(running), 1);
    end

    // Load wins over decrement at A==0.
    do_cycle("pri_load0", 1, 0, 0, 0);
    do_cycle("pri_both", 1, 1, 0, 5);
    check("pri_both/A", 32'(A), 5);
    check("pri_both/borrow", 32'(output_borrow), 0);

    // Periodic with reload value 0: every decrement borrows.
    do_cycle("r0_load", 1, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      do_cycle("r0_dec", 0, 1, 1, 0);
      check("r0_dec/borrow", 32'(output_borrow), 1);
      check("r0_dec/A", 32'(A), 0);
    end

    // Reset in the middle of a count.
    do_cycle("mid_load", 1, 0, 0, 9);
    for (int k = 0; k < 3; k++) do_cycle("mid_dec", 0, 1, 0, 0);
    check("mid_dec/A6", 32'(A), 6);
    apply_reset("mid_rst");
    for (int k = 0; k < 2; k++) do_cycle("mid_after", 0, 1, 0, 0);
    check("mid_after/A", 32'(A), 0);

    // Reset while a borrow pulse is high.
    do_cycle("pulse_load", 1, 0, 1, 0);
    do_cycle("pulse_dec", 0, 1, 1, 0);
    check("pulse_dec/borrow", 32'(output_borrow), 1);
    apply_reset("pulse_rst");
    check("pulse_rst/borrow", 32'(output_borrow), 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        apply_reset("rnd_rst");
      end else begin
        do_cycle("rnd",
                 ($urandom_range(0, 7) == 0) ? 1 : 0,
                 ($urandom_range(0, 3) != 0) ? 1 : 0,
                 int'($urandom_range(0, 1)),
                 int'($urandom_range(0, (1 << W) - 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_timer_with_reload.md
COUNTDOWN_TIMER_WITH_RELOAD -- requirements
Module: countdown_timer_with_reload

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, which sets the counter, load-data and reload-register width.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port clear, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port load, input, 1 bit: parallel-load strobe that captures I.
REQ-005 The block SHALL have port decrement, input, 1 bit: count-down enable.
REQ-006 The block SHALL have port auto_reload, input, 1 bit: mode select, where 1 means periodic reload and 0 means one-shot.
REQ-007 The block SHALL have port I, input, WIDTH bits: parallel load value.
REQ-008 The block SHALL have port A, output, WIDTH bits: current count, driven directly from a register.
REQ-009 The block SHALL have port output_borrow, output, 1 bit: registered one-cycle pulse marking a zero crossing.
REQ-010 The block SHALL have port expired, output, 1 bit: registered level, high while in state EXPIRED.
REQ-011 The block SHALL have port running, output, 1 bit: registered level, high while in state ARMED.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, ARMED and EXPIRED.
REQ-013 The block SHALL keep an internal reload register R of WIDTH bits, written with I on every accepted load.
REQ-014 When load=1, on the edge the block SHALL set A<=I and R<=I, set the next state to ARMED from any state, and leave output_borrow low; load SHALL take priority over decrement.
REQ-015 In IDLE, when load=0, decrement SHALL be ignored: A holds, with no borrow.
REQ-016 In ARMED, when decrement=1, load=0 and A!=0, the block SHALL set A<=A-1, with no borrow.
REQ-017 In ARMED, on a decrement with A==0 and auto_reload=1, the block SHALL set A<=R and stay in ARMED.
REQ-018 In ARMED, on a decrement with A==0 and auto_reload=0, A SHALL hold at 0 (saturate) and the next state SHALL be EXPIRED.
REQ-019 On either zero-crossing case (REQ-017, REQ-018), output_borrow SHALL be high for exactly the one cycle after that edge; the latency is 1 clock.
REQ-020 auto_reload SHALL be sampled only on the zero-crossing edge; changing it at other times SHALL have no effect.
REQ-021 In EXPIRED, decrement SHALL be ignored: A stays 0, no borrow; only load or reset SHALL leave EXPIRED.
REQ-022 Load with I=0 SHALL arm the counter at 0; the next decrement is a zero crossing.
REQ-023 With auto_reload=1 and R=0, every decrement SHALL produce a borrow pulse and A SHALL stay 0.
REQ-024 All arithmetic SHALL be modulo 2^WIDTH with no wrap to all-ones; zero crossings are handled only per REQ-017 and REQ-018.
REQ-025 expired and running SHALL be mutually exclusive; both SHALL be low in IDLE.

Reset
REQ-026 While clear=0, the block SHALL force, without waiting for a clock edge: A=0, R=0, output_borrow=0, expired=0, running=0, state IDLE.
REQ-027 Reset asserted mid-count or mid-borrow-pulse SHALL abort the pulse immediately; the first edge after clear rises SHALL behave as from IDLE.

Verification
REQ-028 The bench SHALL cover: load I=3, auto_reload=0, decrement held 5 cycles -> A=2,1,0,0,0; borrow high only in the cycle after the 4th edge; expired=1 and running=0 after it; no borrow on the 5th.
REQ-029 The bench SHALL cover: load I=2, auto_reload=1, decrement held 9 cycles -> A=1,0,2,1,0,2,1,0,2; borrow pulses after edges 3, 6 and 9; running stays 1.
REQ-030 The bench SHALL cover: A=0 in ARMED, then load=1 with I=5 and decrement=1 on the same edge -> A=5, no borrow, state ARMED.
REQ-031 The bench SHALL cover: after reset, decrement held 5 cycles with no load -> A=0, borrow never high, running=0 and expired=0.
REQ-032 The bench SHALL cover: load I=9, decrement 3 cycles (A=6), then clear driven low between edges -> A=0 and all flags low immediately; decrement after release ignored.
REQ-033 The bench SHALL cover: in EXPIRED, load I=0 with auto_reload=0, then 1 decrement -> borrow pulse once and return to EXPIRED.
